// File: rtl/jt12_kon_seq.sv
// Key-on sequencer: per-channel operator key-on masks scanned by a slot counter.
// Optional CSM (timer A triggered key-on of channel 2) enabled by macro JT12_CSM_EN.
module jt12_kon_seq #(
  parameter int unsigned num_ch = 6
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       zero,
  input  logic       up_keyon,
  input  logic [7:0] din,
  input  logic       csm,
  input  logic       overflow_A,
  output logic       keyon_I,
  output logic [4:0] slot
);

  localparam int unsigned NSLOT   = 4 * num_ch;
  localparam int unsigned LAST    = NSLOT - 1;
  localparam int unsigned CSM_CLR = 3 * num_ch + 2;

  logic [4:0]              cnt;
  logic [num_ch-1:0][3:0]  mask;
  logic                    csm_kon;
  logic [2:0]              wr_ch;
  logic                    wr_ok;
  logic [4:0]              ch;
  logic [1:0]              grp;
  logic [3:0]              cur;
  logic                    op_kon;

  // Channel codes 3 and 7 are holes; codes 4..6 exist only in the 6-channel part.
  always_comb begin
    wr_ch = din[2] ? (3'(din[1:0]) + 3'd3) : 3'(din[1:0]);
    wr_ok = up_keyon && (din[1:0] != 2'd3) && (!din[2] || (num_ch > 3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 5'd0;
      mask <= '0;
    end else if (clk_en) begin
      if (zero)
        cnt <= 5'd1;
      else if (cnt == 5'(LAST))
        cnt <= 5'd0;
      else
        cnt <= cnt + 5'd1;
      for (int i = 0; i < int'(num_ch); i++) begin
        if (wr_ok && (wr_ch == 3'(i)))
          mask[i] <= din[7:4];
      end
    end
  end

`ifdef JT12_CSM_EN
  // Set wins over clear; clear only when leaving channel-2 S4 with the flag already up.
  always_ff @(posedge clk) begin
    if (rst)
      csm_kon <= 1'b0;
    else if (clk_en) begin
      if (csm && overflow_A)
        csm_kon <= 1'b1;
      else if (csm_kon && (cnt == 5'(CSM_CLR)))
        csm_kon <= 1'b0;
    end
  end

  logic unused_din;
  assign unused_din = din[3];
`else
  assign csm_kon = 1'b0;

  logic unused_csm;
  assign unused_csm = ^{csm, overflow_A, din[3]};
`endif

  // Slot -> (operator group, channel); groups are ordered S1,S3,S2,S4.
  always_comb begin
    grp = 2'd0;
    ch  = cnt;
    if (cnt >= 5'(3 * num_ch)) begin
      grp = 2'd3;
      ch  = cnt - 5'(3 * num_ch);
    end else if (cnt >= 5'(2 * num_ch)) begin
      grp = 2'd2;
      ch  = cnt - 5'(2 * num_ch);
    end else if (cnt >= 5'(num_ch)) begin
      grp = 2'd1;
      ch  = cnt - 5'(num_ch);
    end
    cur = 4'd0;
    for (int i = 0; i < int'(num_ch); i++) begin
      if (ch == 5'(i))
        cur = mask[i];
    end
    case (grp)
      2'd0:    op_kon = cur[0];
      2'd1:    op_kon = cur[2];
      2'd2:    op_kon = cur[1];
      default: op_kon = cur[3];
    endcase
  end

  assign keyon_I = op_kon | (csm_kon && (ch == 5'd2));
  assign slot    = cnt;

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Bench for jt12_kon_seq: directed round captures plus randomized traffic against a behavioural model.
module tb_jt12_kon_seq;

  localparam int NCH = 6;

  logic       rst, clk, clk_en, zero, up_keyon, csm, overflow_A;
  logic [7:0] din;
  logic       keyon_I;
  logic [4:0] slot;

  jt12_kon_seq #(.num_ch(NCH)) dut (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .up_keyon(up_keyon),
    .din(din), .csm(csm), .overflow_A(overflow_A), .keyon_I(keyon_I), .slot(slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       total = 0;
  int       bad   = 0;
  bit       chk_on = 1'b0;
  int       m_cnt;
  bit [3:0] m_mask [NCH];
  bit       m_csm;
  int       op_order [4] = '{1, 3, 2, 4};

  // Expected key-on from the model: slot -> channel/operator, then look up the mask.
  function automatic bit exp_kon();
    int c, g, op;
    c  = m_cnt % NCH;
    g  = m_cnt / NCH;
    op = op_order[g];
    return m_mask[c][op-1] | (m_csm && c == 2);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (slot !== 5'(m_cnt) || keyon_I !== exp_kon()) begin
        bad++;
        $display("FAIL cycle t=%0t: slot=%0d keyon=%b required slot=%0d keyon=%b",
                 $time, slot, keyon_I, m_cnt, exp_kon());
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got=0x%0h required=0x%0h", name, got, req);
    end
  endtask

  task automatic tick(input bit en, input bit z, input bit up, input bit [7:0] d,
                      input bit c, input bit o, input bit r);
    int code;
    clk_en = en; zero = z; up_keyon = up; din = d; csm = c; overflow_A = o; rst = r;
    @(posedge clk);
    if (r) begin
      m_cnt = 0;
      m_csm = 1'b0;
      foreach (m_mask[i]) m_mask[i] = 4'd0;
    end else if (en) begin
`ifdef JT12_CSM_EN
      if (c && o) m_csm = 1'b1;
      else if (m_csm && m_cnt == 3 * NCH + 2) m_csm = 1'b0;
`endif
      if (up) begin
        code = int'(d[2:0]);
        if (code != 3 && code != 7 && (code < 3 || NCH == 6))
          m_mask[code < 3 ? code : code - 1] = d[7:4];
      end
      m_cnt = z ? 1 : (m_cnt + 1) % (4 * NCH);
    end
    @(negedge clk);
  endtask

  task automatic idle_tick();
    tick(1'b1, m_cnt == 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write(input bit [7:0] d);
    tick(1'b1, m_cnt == 0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // One full round of clk_en cycles; key-on captured per slot index.
  task automatic round(output bit [23:0] v);
    v = '0;
    for (int i = 0; i < 4 * NCH; i++) begin
      idle_tick();
      v[m_cnt] = keyon_I;
    end
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < 100 && m_cnt != s; i++) idle_tick();
    check_lit("goto_slot", m_cnt, s);
  endtask

  bit [23:0] v;
  bit        en_r, z_r;

  initial begin
    clk_en = 0; zero = 0; up_keyon = 0; din = 0; csm = 0; overflow_A = 0; rst = 1;
    m_cnt = 0; m_csm = 0;
    tick(1'b1, 1'b1, 1'b1, 8'hF1, 1'b1, 1'b1, 1'b1);
    chk_on = 1'b1;
    check_lit("reset_slot", int'(slot), 0);
    check_lit("reset_keyon", int'(keyon_I), 0);

    round(v); check_lit("idle_round0", int'(v), 0);
    round(v); check_lit("idle_round1", int'(v), 0);

    write(8'hF1);
    round(v); check_lit("ch1_all_ops", int'(v), 24'h082082);

    write(8'h25);
    round(v); check_lit("ch4_s2", int'(v), 24'h092082);
    write(8'h05);
    round(v); check_lit("ch4_cleared", int'(v), 24'h082082);

    write(8'hF3);
    write(8'hF7);
    round(v); check_lit("ignored_codes", int'(v), 24'h082082);

    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0);
    check_lit("hold_mask_ch0", int'(m_mask[0]), 0);

    goto_slot(0);
    tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    round(v);
`ifdef JT12_CSM_EN
    check_lit("csm_round", int'(v), 24'h186186);
`else
    check_lit("csm_round", int'(v), 24'h082082);
`endif
    round(v); check_lit("csm_after", int'(v), 24'h082082);

    goto_slot(11);
    tick(1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1);
    check_lit("midrst_slot", int'(slot), 0);
    round(v); check_lit("midrst_round", int'(v), 0);

    for (int i = 0; i < 4000; i++) begin
      en_r = ($urandom_range(0, 3) != 0);
      z_r  = (m_cnt == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 99) == 0);
      tick(en_r, z_r, $urandom_range(0, 5) == 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
